// File: rtl/cache_arbiter.sv
// ============================================================================
//  Module      : cache_arbiter
//  Description : Arbitrates instruction- and data-cache line requests onto a
//                single physical-memory port. Optional round-robin between
//                simultaneous requests is enabled with `ARB_ROUND_ROBIN_EN`;
//                otherwise the data cache has fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ipmem_read,
    input  logic [ADDR_W-1:0] ipmem_address,
    output logic              ipmem_resp,
    output logic [LINE_W-1:0] ipmem_rdata,

    input  logic              dpmem_read,
    input  logic              dpmem_write,
    input  logic [ADDR_W-1:0] dpmem_address,
    input  logic [LINE_W-1:0] dpmem_wdata,
    output logic              dpmem_resp,
    output logic [LINE_W-1:0] dpmem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_READ  = 3'd1,
        D_READ  = 3'd2,
        D_WRITE = 3'd3,
        RECOVER = 3'd4
    } state_t;

    // Clears the byte offset so the memory always sees line-aligned addresses.
    localparam logic [ADDR_W-1:0] c_line_mask = ~(ADDR_W'(31));

    state_t              r_state;
    logic                r_read;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_wdata;

    logic                w_d_req;
    logic                w_grant_d;
    logic                w_grant_i;

    assign w_d_req = dpmem_read | dpmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    // r_ptr = 1 means the instruction side wins the next simultaneous request.
    logic r_ptr;
    assign w_grant_d = w_d_req & (~ipmem_read | ~r_ptr);
`else
    assign w_grant_d = w_d_req;
`endif
    assign w_grant_i = ipmem_read & ~w_grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_addr  <= dpmem_address & c_line_mask;
                        r_wdata <= dpmem_wdata;
                        // A simultaneous read+write is served as a write.
                        if (dpmem_write) begin
                            r_state <= D_WRITE;
                            r_write <= 1'b1;
                        end else begin
                            r_state <= D_READ;
                            r_read  <= 1'b1;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        r_ptr   <= 1'b1;
`endif
                    end else if (w_grant_i) begin
                        r_addr  <= ipmem_address & c_line_mask;
                        r_state <= I_READ;
                        r_read  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        r_ptr   <= 1'b0;
`endif
                    end
                end
                I_READ, D_READ, D_WRITE: begin
                    if (pmem_resp) begin
                        r_state <= RECOVER;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                    end
                end
                RECOVER: r_state <= IDLE;
                default: begin
                    r_state <= IDLE;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = r_read;
    assign pmem_write   = r_write;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;

    assign ipmem_resp   = (r_state == I_READ) & pmem_resp;
    assign dpmem_resp   = ((r_state == D_READ) | (r_state == D_WRITE)) & pmem_resp;
    assign ipmem_rdata  = pmem_rdata;
    assign dpmem_rdata  = pmem_rdata;

endmodule

`default_nettype wire
